mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Sequences and shares the single byte-addressable data memory between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Converts a level req/done handshake into clean, glitch-free memRead/memWrite strobes, with address, data and byte mode held stable around each strobe.
- Captures read data into per-port registers.
- Sits between the core datapath and the memory; it is the only driver of the memory's control inputs.

Parameters:
- ADDR_W, 18, byte address width to memory
- DATA_W, 32, data width
- ACCESS_CYCLES, 1, cycles the read/write strobe is held high (1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req0 / req1  input  1  access request, held until matching done
- addr0 / addr1  input  ADDR_W  byte address
- wdata0 / wdata1  input  DATA_W  write data
- we0 / we1  input  1  1 = write, 0 = read
- byte0 / byte1  input  1  1 = byte access, 0 = word access
- done0 / done1  output  1  one-cycle completion pulse
- err0 / err1  output  1  one-cycle pulse with done: misaligned word access
- rdata0 / rdata1  output  DATA_W  captured read data, held until the next read done on that port
- mem_address  output  ADDR_W  to memory address
- mem_write_data  output  DATA_W  to memory write_data
- mem_read  output  1  to memory memRead
- mem_write  output  1  to memory memWrite
- mem_byte  output  1  to memory byteOperations
- mem_read_data  input  DATA_W  from memory read_data
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs go to 0; mem_read and mem_write drop in the same instant.
  - last_grant goes to 1.
  - A reset mid-access abandons the access, with no done pulse. Partial memory writes are not repaired.

- FSM, IDLE:
  - If any req is high, select a port, latch its addr/wdata/we/byte into internal registers, then go to SETUP.
  - Selection: if exactly one req is high, grant that port. If both are high, grant the port != last_grant.
  - last_grant updates on the grant edge.
- FSM, SETUP:
  - mem_address, mem_write_data and mem_byte are driven from the latched values; both strobes stay low.
  - If the access is a word access (byte=0) and addr[1:0] != 0, go to FINISH with the error flag set. No strobe is issued.
  - Otherwise go to STROBE.
- FSM, STROBE:
  - mem_read (we=0) or mem_write (we=1) is high.
  - A cycle counter loads ACCESS_CYCLES on entry. After ACCESS_CYCLES cycles, go to FINISH.
- FSM, FINISH:
  - Both strobes are low.
  - done of the granted port is high for exactly this cycle; err is high alongside it if flagged.
  - Read without error: rdata of that port <= mem_read_data sampled on the edge entering FINISH. For a byte read, bits [DATA_W-1:8] are forced to 0.
  - Write or error: rdata is unchanged.
  - Next state is always IDLE.

- Timing:
  - Latency from the IDLE edge that samples req to done high is 2+ACCESS_CYCLES cycles: 3 with default.
  - Minimum spacing between grants is 3+ACCESS_CYCLES cycles, because IDLE is a mandatory bubble.
- Requester handshake:
  - Keep req and payload stable until done is sampled high.
  - Drop req on that same edge, or keep it high to issue a new request.
  - The controller ignores payload changes after the grant edge.
- Invariants:
  - mem_read and mem_write are never high simultaneously.
  - mem_address, mem_write_data and mem_byte are stable from the start of SETUP through the end of FINISH, i.e. at least one cycle before the strobe rises and one cycle after it falls.
  - In IDLE, the memory-side data and address outputs hold their last values and the strobes are low.
  - At most one done is high in any cycle.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1. The first tie after reset goes to port 0.
- A req asserted during a busy access waits; it is never dropped.

Test Plan:
- Word write then read, port 1: write addr=0x010, wdata=0xDEADBEEF, then read addr=0x010 -> mem_write high exactly 1 cycle; done1 3 cycles after grant; read gives rdata1=0xDEADBEEF, err1=0.
- Byte access, port 0: byte write addr=0x021, wdata=0x000000A5, then byte read addr=0x021 -> mem_byte=1 during access; rdata0=0x000000A5, upper bits 0.
- Misaligned word read addr=0x006 on port 1 -> no mem_read/mem_write pulse; done1 and err1 high together 2 cycles after grant; rdata1 unchanged.
- Contention: req0 and req1 held high from reset for 4 accesses -> grant order 0,1,0,1; done0 and done1 never coincide; done pulses 4 cycles apart.
- Reset mid-access: assert reset while mem_write is high with ACCESS_CYCLES=3 -> mem_write and busy drop asynchronously; no done pulse; first request after release is serviced normally.
- Stability check, randomized 200 accesses: assert address/data/byte are unchanged for the whole window in which mem_read or mem_write is high, plus one cycle either side; strobes are never both high; a scoreboard matches rdata.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one byte-addressable data memory between
// instruction fetch (port 0) and the load/store unit (port 1).
module mem_access_arbiter #(
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  input  logic              byte0,
  input  logic              byte1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    FINISH
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES);

  state_t            state;
  state_t            state_n;
  logic              last_grant;
  logic              gnt_q;
  logic              gnt_n;
  logic              grant;
  logic              we_q;
  logic              byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;
  logic              mis;
  logic              rd_n;
  logic              wr_n;
  logic              done_n;
  logic              err_n;
  logic              capture;
  logic [DATA_W-1:0] rd_cap;

  assign mis            = ~byte_q & (addr_q[1:0] != 2'b00);
  assign busy           = (state != IDLE);
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_byte       = byte_q;

  assign rd_cap = byte_q ?
    {{(DATA_W-8){1'b0}}, mem_read_data[7:0]} : mem_read_data;

  // Strobes and done/err are computed for the next state and registered,
  // so the memory never sees decode glitches on its control inputs.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    gnt_n   = gnt_q;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant   = 1'b1;
          gnt_n   = (req0 & req1) ? ~last_grant : req1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (mis) begin
          state_n = FINISH;
          err_n   = 1'b1;
        end else begin
          state_n = STROBE;
          rd_n    = ~we_q;
          wr_n    = we_q;
        end
      end
      STROBE: begin
        if (cnt != 4'd1) begin
          rd_n = ~we_q;
          wr_n = we_q;
        end else begin
          state_n = FINISH;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    done_n  = (state_n == FINISH);
    capture = (state == STROBE) & (state_n == FINISH) & ~we_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state     <= state_n;
      mem_read  <= rd_n;
      mem_write <= wr_n;
      done0     <= done_n & ~gnt_q;
      done1     <= done_n & gnt_q;
      err0      <= err_n & ~gnt_q;
      err1      <= err_n & gnt_q;
      if (grant) begin
        gnt_q      <= gnt_n;
        last_grant <= gnt_n;
        addr_q     <= gnt_n ? addr1 : addr0;
        wdata_q    <= gnt_n ? wdata1 : wdata0;
        we_q       <= gnt_n ? we1 : we0;
        byte_q     <= gnt_n ? byte1 : byte0;
      end
      if (state == SETUP) begin
        cnt <= CNT_INIT;
      end else if (state == STROBE) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        if (gnt_q) begin
          rdata1 <= rd_cap;
        end else begin
          rdata0 <= rd_cap;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: a byte-array reference model
// predicts each access; a negedge monitor checks completions and invariants.
module tb_mem_access_arbiter;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam int AC = 3;

  typedef struct {
    logic          err;
    logic          we;
    logic          is_byte;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          we0 = 1'b0;
  logic          we1 = 1'b0;
  logic          byte0 = 1'b0;
  logic          byte1 = 1'b0;
  logic          done0;
  logic          done1;
  logic          err0;
  logic          err1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read;
  logic          mem_write;
  logic          mem_byte;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  // memory behind the DUT, and the independent reference image
  logic [7:0] phys [1024] = '{default: 8'h00};
  logic [7:0] rmem [1024] = '{default: 8'h00};
  logic [DW-1:0] mrd [2] = '{default: '0};
  exp_t q0[$];
  exp_t q1[$];
  int done_log[$];
  int done_cyc[$];

  mem_access_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .ACCESS_CYCLES(AC)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .req0(req0),
    .req1(req1),
    .addr0(addr0),
    .addr1(addr1),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .we0(we0),
    .we1(we1),
    .byte0(byte0),
    .byte1(byte1),
    .done0(done0),
    .done1(done1),
    .err0(err0),
    .err1(err1),
    .rdata0(rdata0),
    .rdata1(rdata1),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_byte(mem_byte),
    .mem_read_data(mem_read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [9:0] pa;
  assign pa = mem_address[9:0];
  assign mem_read_data = mem_read ?
    {phys[pa+10'd3], phys[pa+10'd2], phys[pa+10'd1], phys[pa]} :
    32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_write) begin
      phys[pa] <= mem_write_data[7:0];
      if (!mem_byte) begin
        phys[pa+10'd1] <= mem_write_data[15:8];
        phys[pa+10'd2] <= mem_write_data[23:16];
        phys[pa+10'd3] <= mem_write_data[31:24];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // predict, enqueue, then drive one request and hold it until done
  task automatic issue(input int p, input logic [AW-1:0] a,
                       input logic w, input logic b,
                       input logic [DW-1:0] d);
    exp_t e;
    logic [9:0] i;
    int n;
    logic seen;
    i = a[9:0];
    e.err = !b && (a[1:0] != 2'b00);
    e.we = w;
    e.is_byte = b;
    e.addr = a;
    e.wdata = d;
    if (!e.err && w) begin
      rmem[i] = d[7:0];
      if (!b) begin
        rmem[i+10'd1] = d[15:8];
        rmem[i+10'd2] = d[23:16];
        rmem[i+10'd3] = d[31:24];
      end
    end
    if (!e.err && !w) begin
      mrd[p] = b ? {24'h0, rmem[i]} :
        {rmem[i+10'd3], rmem[i+10'd2], rmem[i+10'd1], rmem[i]};
    end
    e.rdata = mrd[p];
    if (p == 0) begin
      q0.push_back(e);
      addr0 = a; wdata0 = d; we0 = w; byte0 = b; req0 = 1'b1;
    end else begin
      q1.push_back(e);
      addr1 = a; wdata1 = d; we1 = w; byte1 = b; req1 = 1'b1;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = (p == 0) ? done0 : done1;
    end
    if (!seen) chk($sformatf("p%0d_done_timeout", p), seen, 1);
    if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic rand_port(input int p);
    logic [AW-1:0] a;
    logic w;
    logic b;
    for (int k = 0; k < 100; k++) begin
      a = AW'((p * 256) + $urandom_range(0, 239));
      b = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!b && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      issue(p, a, w, b, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // monitor: invariants every cycle, scoreboard pop on each done
  int cyc = 0;
  int bcnt = 0;
  int rdc = 0;
  int wrc = 0;
  logic prev_busy = 1'b0;
  logic [AW-1:0] sa = '0;
  logic [DW-1:0] sd = '0;
  logic sb = 1'b0;
  exp_t me;
  logic have;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_busy = 1'b0;
      sa = '0;
      sd = '0;
      sb = 1'b0;
      bcnt = 0;
      mrd[0] = '0;
      mrd[1] = '0;
    end else begin
      chk("strobe_excl", mem_read & mem_write, 0);
      chk("done_excl", done0 & done1, 0);
      chk("err_only_with_done", (err0 & ~done0) | (err1 & ~done1), 0);
      if (!busy) chk("idle_strobe", mem_read | mem_write, 0);
      if (busy && !prev_busy) begin
        bcnt = 1;
        rdc = 0;
        wrc = 0;
      end else begin
        chk("addr_stable", mem_address, sa);
        chk("wdata_stable", mem_write_data, sd);
        chk("byte_stable", mem_byte, sb);
        if (busy) bcnt++;
      end
      rdc += int'(mem_read);
      wrc += int'(mem_write);
      sa = mem_address;
      sd = mem_write_data;
      sb = mem_byte;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? done0 : done1) begin
          have = 1'b0;
          if (p == 0) begin
            chk("p0_expected", q0.size() != 0, 1);
            if (q0.size() != 0) begin me = q0.pop_front(); have = 1'b1; end
          end else begin
            chk("p1_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin me = q1.pop_front(); have = 1'b1; end
          end
          if (have) begin
            chk($sformatf("p%0d_err", p), (p == 0) ? err0 : err1, me.err);
            chk($sformatf("p%0d_rdata", p),
                (p == 0) ? rdata0 : rdata1, me.rdata);
            chk($sformatf("p%0d_addr", p), mem_address, me.addr);
            chk($sformatf("p%0d_byte", p), mem_byte, me.is_byte);
            if (me.we) chk($sformatf("p%0d_wdata", p), mem_write_data, me.wdata);
            chk($sformatf("p%0d_latency", p), bcnt, me.err ? 2 : 2 + AC);
            chk($sformatf("p%0d_rd_cycles", p), rdc,
                (!me.err && !me.we) ? AC : 0);
            chk($sformatf("p%0d_wr_cycles", p), wrc,
                (!me.err && me.we) ? AC : 0);
          end
          done_log.push_back(p);
          done_cyc.push_back(cyc);
        end
      end
      prev_busy = busy;
    end
  end

  int s;
  logic saw;
  int n;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_err", {err1, err0}, 0);
    chk("rst_strobes", {mem_write, mem_read}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_byte", mem_byte, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    #2 reset = 1'b0;

    // contention from reset: both ports keep requesting
    s = done_log.size();
    fork
      begin
        issue(0, 18'h040, 1'b0, 1'b0, 32'h0);
        issue(0, 18'h044, 1'b0, 1'b0, 32'h0);
      end
      begin
        issue(1, 18'h140, 1'b0, 1'b0, 32'h0);
        issue(1, 18'h141, 1'b0, 1'b1, 32'h0);
      end
    join
    @(negedge clk);
    chk("cont_count", done_log.size() - s, 4);
    if (done_log.size() - s >= 4) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("cont_order%0d", k), done_log[s+k], k % 2);
      for (int k = 1; k < 4; k++)
        chk($sformatf("cont_gap%0d", k),
            done_cyc[s+k] - done_cyc[s+k-1], 3 + AC);
    end

    // directed: word write/read, byte write/read, misaligned word
    issue(1, 18'h010, 1'b1, 1'b0, 32'hDEAD_BEEF);
    issue(1, 18'h010, 1'b0, 1'b0, 32'h0);
    chk("wr_rd_p1", rdata1, 32'hDEAD_BEEF);
    issue(0, 18'h021, 1'b1, 1'b1, 32'h0000_00A5);
    issue(0, 18'h021, 1'b0, 1'b1, 32'h0);
    chk("byte_rd_p0", rdata0, 32'h0000_00A5);
    issue(0, 18'h010, 1'b0, 1'b1, 32'h0);
    chk("byte_rd_mask", rdata0, 32'h0000_00EF);
    issue(1, 18'h006, 1'b0, 1'b0, 32'h0);
    chk("misaligned_keep", rdata1, 32'hDEAD_BEEF);

    // reset while the write strobe is high
    @(negedge clk);
    addr1 = 18'h1F0; wdata1 = 32'h1234_5678; we1 = 1'b1; byte1 = 1'b0;
    req1 = 1'b1;
    n = 0;
    while (!mem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_strobe_seen", mem_write, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_write", mem_write, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_read", mem_read, 0);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw = saw | done0 | done1;
    end
    chk("rst_mid_no_done", saw, 0);
    issue(1, 18'h1F4, 1'b0, 1'b0, 32'h0);
    chk("post_rst_read", rdata1, 32'h0);

    // randomized traffic, disjoint address regions per port
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (2) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
